// File: rtl/apb_bus_arbiter.sv
// Two-port round-robin arbiter in front of an APB master, with optional bus lock
// for atomic sequences and registered request/response paths.
module apb_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              m0_transfer,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_transfer,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              transfer,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_last_owner;
    logic              r_owner;
    logic              r_locked;
    logic              r_lock_req;
    logic [7:0]        r_lock_cnt;
    logic              r_transfer;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_grant;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m0_ready;
    logic              r_m1_ready;

    logic              w_lock_hold;
    logic              w_req_any;
    logic              w_pick_m1;
    logic [8:0]        w_lock_next;

    // A held lock keeps the bus only while its owner is still asking for it.
    assign w_lock_hold = r_locked && (r_last_owner ? m1_transfer : m0_transfer);
    assign w_req_any   = m0_transfer | m1_transfer;
    assign w_lock_next = {1'b0, r_lock_cnt} + 9'd1;

    always_comb begin
        w_pick_m1 = 1'b0;
        if (w_lock_hold)
            w_pick_m1 = r_last_owner;
        else if (m0_transfer && m1_transfer)
            w_pick_m1 = ~r_last_owner;
        else
            w_pick_m1 = m1_transfer;
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_req   <= 1'b0;
            r_lock_cnt   <= '0;
            r_transfer   <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_grant      <= 2'b00;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_lock_hold) begin
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    if (w_req_any) begin
                        r_owner    <= w_pick_m1;
                        r_grant    <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_write    <= w_pick_m1 ? m1_write : m0_write;
                        r_addr     <= w_pick_m1 ? m1_addr  : m0_addr;
                        r_wdata    <= w_pick_m1 ? m1_wdata : m0_wdata;
                        r_lock_req <= w_pick_m1 ? m1_lock  : m0_lock;
                        r_transfer <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_transfer <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (ready) begin
                        if (r_owner) begin
                            r_m1_rdata <= rdata;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= rdata;
                            r_m0_ready <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_m0_ready   <= 1'b0;
                    r_m1_ready   <= 1'b0;
                    r_last_owner <= r_owner;
                    r_grant      <= 2'b00;
                    // Forced release once LOCK_MAX consecutive locked transfers are done.
                    if (r_lock_req && (w_lock_next < 9'(LOCK_MAX))) begin
                        r_locked   <= 1'b1;
                        r_lock_cnt <= w_lock_next[7:0];
                    end else begin
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign transfer = r_transfer;
    assign write    = r_write;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign grant    = r_grant;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
- Two-requester arbiter sharing the single internal bus into the APB master between the CPU (port m0) and a second bus master such as a DMA or debug engine (port m1).
- Sits between the requesters and the APB master's transfer/ready/write/addr/wdata/rdata interface.
- Round-robin grant, optional bus lock for atomic sequences, registered request and response paths.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_MAX, 4, maximum consecutive locked transfers before a forced release (range 1..255).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-low reset.
- m0_transfer  in  1  m0 request; held high until m0_ready.
- m0_write  in  1  m0 1=write, 0=read.
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_lock  in  1  m0 requests to keep the bus after this transfer.
- m0_rdata  out  DATA_W  m0 read data, valid with m0_ready.
- m0_ready  out  1  m0 one-cycle completion pulse.
- m1_transfer, m1_write, m1_addr, m1_wdata, m1_lock, m1_rdata, m1_ready: same as m0, for port m1.
- transfer  out  1  one-cycle start pulse to the APB master.
- write  out  1  to APB master.
- addr  out  ADDR_W  to APB master.
- wdata  out  DATA_W  to APB master.
- rdata  in  DATA_W  from APB master.
- ready  in  1  completion pulse from APB master.
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (PRESET=0, asynchronous): FSM=IDLE; last_owner=1; lock_cnt=0; locked=0.
  - All outputs 0 (transfer, write, addr, wdata, grant, m*_ready, m*_rdata).
  - Reset mid-transfer abandons it; no m*_ready is issued.
- FSM states: IDLE, SETUP, WAIT, RESP.
- IDLE: sample m0_transfer and m1_transfer.
  - If locked=1 and the owner's transfer is high: grant the owner.
  - If locked=1 and the owner's transfer is low: clear locked and lock_cnt, then arbitrate normally in the same cycle.
  - Only one request: grant it.
  - Both requests: grant the port != last_owner (m0 wins the first tie after reset).
  - On a grant: register write/addr/wdata from the winner, set grant, go to SETUP.
  - No request: stay in IDLE; grant=00.
- SETUP (1 cycle): transfer=1; go to WAIT.
- WAIT: transfer=0; write/addr/wdata held stable.
  - On ready=1: capture rdata into the owner's m*_rdata and go to RESP.
  - No timeout; waits indefinitely.
- RESP (1 cycle): owner's m*_ready=1; the other port's ready stays 0; last_owner=owner.
  - Lock update:
    - If the owner's lock=1 and lock_cnt+1 < LOCK_MAX: locked=1, lock_cnt increments.
    - Otherwise: locked=0, lock_cnt=0 (forced release after LOCK_MAX consecutive locked transfers).
  - Go to IDLE; grant is cleared on entry to IDLE.
- Latency:
  - Request seen in an IDLE cycle N gives transfer=1 in cycle N+1.
  - ready in cycle K gives m*_ready in cycle K+1.
  - Minimum per-transfer occupancy is IDLE+SETUP+WAIT+RESP = 4 cycles with ready in the first WAIT cycle.
- Requester rule: drop or replace m*_transfer at the clock edge ending the m*_ready cycle. The arbiter never re-issues the same request because it returns to IDLE after RESP.
- Request-side inputs are sampled only in IDLE; changes during SETUP/WAIT/RESP are ignored.
- The non-owner's m*_rdata holds its previous value.
- ready outside WAIT is ignored.
- Downstream write/addr/wdata retain their last values in IDLE (no return to 0).

Test Plan:
- Single write: m0 writes addr=0x1000_2000, wdata=0xA5, ready one cycle after transfer.
  - Required: transfer pulses 1 cycle with write=1, addr=0x1000_2000, wdata=0xA5; m0_ready pulses 1 cycle after ready; grant=01 during SETUP..RESP.
- Read with wait states: m1 reads addr=0x1000_3004; ready asserted 3 cycles after transfer with rdata=0x0000_00C3.
  - Required: m1_rdata=0xC3 and m1_ready=1 in the cycle after ready; addr stable throughout WAIT; m0_ready=0.
- Tie/round-robin: m0 and m1 request continuously from reset, lock=0.
  - Required: grant order m0, m1, m0, m1; each port gets m*_ready exactly once per transfer.
- Lock, LOCK_MAX=4: m0 holds lock=1 for 6 transfers; m1 requests continuously.
  - Required: m0 is granted 4 consecutive transfers, then m1, then m0 resumes.
  - With m0_lock=0 on its 2nd transfer, m1 is granted next.
- Reset mid-operation: assert PRESET=0 during WAIT of an m1 read.
  - Required: immediately transfer=0, grant=00, m1_ready=0, m1_rdata=0; after release, an m0 request is granted first (last_owner=1).
- Spurious ready: pulse ready while in IDLE, then issue an m0 read.
  - Required: no m*_ready from the spurious pulse; the m0 read completes normally with exactly one m0_ready.
